// File: rtl/firefly_pwm_multi_if.sv
// Host-side bundle for firefly_pwm_multi: control/status register port plus
// the per-channel configuration request/busy handshake.
interface firefly_pwm_multi_if #(
    parameter int PWM_WIDTH = 8
) ();
    logic [31:0]          c_in;
    logic                 c_we;
    logic [31:0]          c_out;
    logic [3:0]           cfg_ch;
    logic [PWM_WIDTH-1:0] cfg_duty;
    logic                 cfg_mode;
    logic                 cfg_req;
    logic                 cfg_busy;

    modport master (
        output c_in, c_we, cfg_ch, cfg_duty, cfg_mode, cfg_req,
        input  c_out, cfg_busy
    );

    modport slave (
        input  c_in, c_we, cfg_ch, cfg_duty, cfg_mode, cfg_req,
        output c_out, cfg_busy
    );
endinterface

// File: rtl/firefly_pwm_multi.sv
// Multi-channel LED PWM: one shared prescaled period counter drives CHANNELS
// outputs, each either at a static duty or breathing up/down once per period.
module firefly_pwm_multi #(
    parameter int CHANNELS       = 4,
    parameter int PWM_WIDTH      = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    firefly_pwm_multi_if.slave  bus,
    output logic [CHANNELS-1:0] led_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } cfg_state_t;

    localparam logic [PWM_WIDTH-1:0] PWM_MAX  = {PWM_WIDTH{1'b1}};
    localparam logic [PWM_WIDTH-1:0] PWM_ZERO = {PWM_WIDTH{1'b0}};
    localparam logic [PWM_WIDTH-1:0] PWM_ONE  = {{(PWM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic                 DIR_UP   = 1'b0;
    localparam logic                 DIR_DOWN = 1'b1;

    cfg_state_t                state_q, state_d;
    logic [3:0]                ch_q, ch_d;
    logic [PWM_WIDTH-1:0]      cduty_q, cduty_d;
    logic                      cmode_q, cmode_d;
    logic                      busy_q, busy_d;

    logic                      enable_q, enable_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [PWM_WIDTH-1:0]      pwm_cnt_q, pwm_cnt_d;

    logic [PWM_WIDTH-1:0]      duty_q  [CHANNELS];
    logic [PWM_WIDTH-1:0]      duty_d  [CHANNELS];
    logic [PWM_WIDTH-1:0]      level_q [CHANNELS];
    logic [PWM_WIDTH-1:0]      level_d [CHANNELS];
    logic [CHANNELS-1:0]       mode_q, mode_d;
    logic [CHANNELS-1:0]       dir_q, dir_d;
    logic [CHANNELS-1:0]       led_q, led_d;
    logic [CHANNELS-1:0]       step_s;
    logic                      flag_q, flag_d;

    logic                      tick_s;
    logic                      period_end_s;
    logic                      load_s;
    logic [PWM_WIDTH-1:0]      eff_s   [CHANNELS];
    logic                      ctrl_unused_s;

    assign ctrl_unused_s = ^bus.c_in[15:1];

    // Configuration FSM next state; latches the request only while idle.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cduty_d = cduty_q;
        cmode_d = cmode_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_req) begin
                    ch_d    = bus.cfg_ch;
                    cduty_d = bus.cfg_duty;
                    cmode_d = bus.cfg_mode;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control register, prescaler and shared period counter.
    always_comb begin
        enable_d   = enable_q;
        prescale_d = prescale_q;
        tick_s     = enable_q && (pre_cnt_q == prescale_q);
        if (bus.c_we) begin
            enable_d   = bus.c_in[0];
            prescale_d = bus.c_in[16 +: PRESCALE_WIDTH];
        end else begin
            enable_d   = enable_q;
            prescale_d = prescale_q;
        end
        if (bus.c_we || tick_s) begin
            pre_cnt_d = {PRESCALE_WIDTH{1'b0}};
        end else if (enable_q) begin
            pre_cnt_d = pre_cnt_q + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            pre_cnt_d = pre_cnt_q;
        end
        if (tick_s) begin
            pwm_cnt_d = pwm_cnt_q + PWM_ONE;
        end else begin
            pwm_cnt_d = pwm_cnt_q;
        end
        period_end_s = tick_s && (pwm_cnt_q == PWM_MAX);
        load_s       = (state_q == ST_LOAD) && ({1'b0, ch_q} < 5'(CHANNELS));
    end

    // Per-channel duty/level update; a config write overrides a breath step.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            duty_d[i]  = duty_q[i];
            level_d[i] = level_q[i];
            mode_d[i]  = mode_q[i];
            dir_d[i]   = dir_q[i];
            step_s[i]  = 1'b0;
            if (load_s && (ch_q == 4'(i))) begin
                duty_d[i]  = cduty_q;
                mode_d[i]  = cmode_q;
                level_d[i] = cduty_q;
                dir_d[i]   = (cduty_q == PWM_MAX) ? DIR_DOWN : DIR_UP;
            end else if (period_end_s && mode_q[i]) begin
                step_s[i] = 1'b1;
                if (dir_q[i] == DIR_UP) begin
                    level_d[i] = (level_q[i] == PWM_MAX) ? PWM_MAX : level_q[i] + PWM_ONE;
                    dir_d[i]   = (level_d[i] == PWM_MAX) ? DIR_DOWN : DIR_UP;
                end else begin
                    level_d[i] = (level_q[i] == PWM_ZERO) ? PWM_ZERO : level_q[i] - PWM_ONE;
                    dir_d[i]   = (level_d[i] == PWM_ZERO) ? DIR_UP : DIR_DOWN;
                end
            end else begin
                level_d[i] = level_q[i];
                dir_d[i]   = dir_q[i];
            end
            eff_s[i] = mode_q[i] ? level_q[i] : duty_q[i];
            led_d[i] = enable_q && (pwm_cnt_q < eff_s[i]);
        end
    end

    // Channel 0 completes a breath when a down-step lands on zero.
    always_comb begin
        if (step_s[0] && (dir_q[0] == DIR_DOWN) && (level_q[0] == PWM_ONE)) begin
            flag_d = ~flag_q;
        end else begin
            flag_d = flag_q;
        end
    end

    // Configuration FSM state and latched request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ch_q    <= 4'd0;
            cduty_q <= PWM_ZERO;
            cmode_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cduty_q <= cduty_d;
            cmode_q <= cmode_d;
            busy_q  <= busy_d;
        end
    end

    // Control, counters, breath flag and LED drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q   <= 1'b0;
            prescale_q <= {PRESCALE_WIDTH{1'b0}};
            pre_cnt_q  <= {PRESCALE_WIDTH{1'b0}};
            pwm_cnt_q  <= PWM_ZERO;
            flag_q     <= 1'b0;
            led_q      <= {CHANNELS{1'b0}};
            mode_q     <= {CHANNELS{1'b0}};
            dir_q      <= {CHANNELS{DIR_UP}};
        end else begin
            enable_q   <= enable_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            flag_q     <= flag_d;
            led_q      <= led_d;
            mode_q     <= mode_d;
            dir_q      <= dir_d;
        end
    end

    // Per-channel duty and breathing level storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_q[i]  <= PWM_ZERO;
                level_q[i] <= PWM_ZERO;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_q[i]  <= duty_d[i];
                level_q[i] <= level_d[i];
            end
        end
    end

    assign led_out      = led_q;
    assign bus.cfg_busy = busy_q;
    assign bus.c_out    = {16'(prescale_q), 13'd0, busy_q, enable_q, flag_q};

endmodule
